// File: rtl/mem_port_arbiter.sv
// Two-port (CPU / debug loader) arbiter in front of a single unified memory.
// Optional feature macro: MEM_ARB_RR_EN selects round-robin tie-breaking; undefined gives fixed CPU priority.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic          o_cpu_gnt,
  output logic          o_cpu_rvalid,
  output logic [DW-1:0] o_cpu_rdata,
  input  logic          i_dbg_req,
  input  logic          i_dbg_we,
  input  logic [AW-1:0] i_dbg_addr,
  input  logic [DW-1:0] i_dbg_wdata,
  output logic          o_dbg_gnt,
  output logic          o_dbg_rvalid,
  output logic [DW-1:0] o_dbg_rdata,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_busy,
  output logic          o_owner
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  if ((MEM_LAT < 1) || (MEM_LAT > 8)) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must be in 1..8");
  end

  localparam logic [2:0] WAIT_LOAD = 3'(MEM_LAT - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [2:0]    r_cnt;
  logic [2:0]    w_cnt_next;
  logic          w_grant;
  logic          w_capture;
  logic          w_win;
  logic          r_owner;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;

  // Port 0 = CPU, port 1 = debug; index matches the owner encoding.
  logic          w_we    [2];
  logic [AW-1:0] w_addr  [2];
  logic [DW-1:0] w_wdata [2];

  assign w_we[0]    = i_cpu_we;
  assign w_we[1]    = i_dbg_we;
  assign w_addr[0]  = i_cpu_addr;
  assign w_addr[1]  = i_dbg_addr;
  assign w_wdata[0] = i_cpu_wdata;
  assign w_wdata[1] = i_dbg_wdata;

`ifdef MEM_ARB_RR_EN
  logic r_last_owner;

  assign w_win = (i_cpu_req && i_dbg_req) ? ~r_last_owner : i_dbg_req;

  // Resets to debug so that the CPU takes the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_owner <= 1'b1;
    end else if (w_grant) begin
      r_last_owner <= w_win;
    end
  end
`else
  assign w_win = ~i_cpu_req & i_dbg_req;
`endif

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_grant      = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_cpu_req || i_dbg_req) begin
          w_grant      = 1'b1;
          w_state_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_mem_we) begin
          w_state_next = S_IDLE;
        end else if (MEM_LAT > 1) begin
          w_state_next = S_WAIT;
          w_cnt_next   = WAIT_LOAD;
        end else begin
          w_state_next = S_RESP;
          w_capture    = 1'b1;
        end
      end
      S_WAIT: begin
        // Read data is captured on the edge that enters RESP.
        if (r_cnt <= 3'd1) begin
          w_state_next = S_RESP;
          w_capture    = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 3'd1;
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_owner     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_mem_en <= w_grant;
      if (w_grant) begin
        r_owner     <= w_win;
        r_mem_we    <= w_we[w_win];
        r_mem_addr  <= w_addr[w_win];
        r_mem_wdata <= w_wdata[w_win];
      end else begin
        r_mem_we <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    localparam logic PORT_ID = 1'(gi);
    logic          r_gnt;
    logic          r_rvalid;
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_gnt    <= 1'b0;
        r_rvalid <= 1'b0;
        r_rdata  <= '0;
      end else begin
        r_gnt    <= w_grant && (w_win == PORT_ID);
        r_rvalid <= w_capture && (r_owner == PORT_ID);
        if (w_capture && (r_owner == PORT_ID)) begin
          r_rdata <= i_mem_rdata;
        end
      end
    end
  end

  assign o_cpu_gnt    = g_port[0].r_gnt;
  assign o_cpu_rvalid = g_port[0].r_rvalid;
  assign o_cpu_rdata  = g_port[0].r_rdata;
  assign o_dbg_gnt    = g_port[1].r_gnt;
  assign o_dbg_rvalid = g_port[1].r_rvalid;
  assign o_dbg_rdata  = g_port[1].r_rdata;
  assign o_mem_en     = r_mem_en;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_owner      = r_owner;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 1, 3, 4), one active at a time, with a memory model
// and a read-response scoreboard.
module tb_mem_port_arbiter;

  localparam logic [11:0] LAT_PACK = 12'h431;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  int          sel   = 0;
  int          cyc   = 0;
  int          n_checks = 0;
  int          n_errs   = 0;

  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;

  logic        cpu_gnt_a [3], cpu_rvalid_a [3], dbg_gnt_a [3], dbg_rvalid_a [3];
  logic        mem_en_a [3], mem_we_a [3], busy_a [3], owner_a [3];
  logic [31:0] cpu_rdata_a [3], dbg_rdata_a [3], mem_addr_a [3], mem_wdata_a [3];

  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we, busy, owner;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    bit          port;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb_q [$];
  exp_t        mon_e;
  logic [31:0] ref_wr [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    mem_port_arbiter #(
      .AW(32), .DW(32), .MEM_LAT(int'(LAT_PACK[gi*4 +: 4]))
    ) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_cpu_req   (cpu_req && (sel == gi)),
      .i_cpu_we    (cpu_we),
      .i_cpu_addr  (cpu_addr),
      .i_cpu_wdata (cpu_wdata),
      .o_cpu_gnt   (cpu_gnt_a[gi]),
      .o_cpu_rvalid(cpu_rvalid_a[gi]),
      .o_cpu_rdata (cpu_rdata_a[gi]),
      .i_dbg_req   (dbg_req && (sel == gi)),
      .i_dbg_we    (dbg_we),
      .i_dbg_addr  (dbg_addr),
      .i_dbg_wdata (dbg_wdata),
      .o_dbg_gnt   (dbg_gnt_a[gi]),
      .o_dbg_rvalid(dbg_rvalid_a[gi]),
      .o_dbg_rdata (dbg_rdata_a[gi]),
      .o_mem_en    (mem_en_a[gi]),
      .o_mem_we    (mem_we_a[gi]),
      .o_mem_addr  (mem_addr_a[gi]),
      .o_mem_wdata (mem_wdata_a[gi]),
      .i_mem_rdata (mem_rdata),
      .o_busy      (busy_a[gi]),
      .o_owner     (owner_a[gi])
    );
  end

  always_comb begin
    cpu_gnt    = cpu_gnt_a[sel];
    cpu_rvalid = cpu_rvalid_a[sel];
    cpu_rdata  = cpu_rdata_a[sel];
    dbg_gnt    = dbg_gnt_a[sel];
    dbg_rvalid = dbg_rvalid_a[sel];
    dbg_rdata  = dbg_rdata_a[sel];
    mem_en     = mem_en_a[sel];
    mem_we     = mem_we_a[sel];
    mem_addr   = mem_addr_a[sel];
    mem_wdata  = mem_wdata_a[sel];
    busy       = busy_a[sel];
    owner      = owner_a[sel];
  end

  function automatic int cur_lat();
    return int'(LAT_PACK[sel*4 +: 4]);
  endfunction

  function automatic logic [31:0] init_word(input logic [7:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    if (a == 8'h14) return 32'hCAFEF00D;
    return {24'hA5A5A5, a};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [7:0] a);
    if (ref_wr.exists(int'(a))) return ref_wr[int'(a)];
    return init_word(a);
  endfunction

  // Memory model: read word is present during the access cycle, then delayed MEM_LAT-1 cycles.
  logic [31:0] mem_arr [256];
  logic [31:0] pipe [8];
  logic [31:0] rd_comb;
  int          lat_now;

  always_comb begin
    lat_now   = cur_lat();
    rd_comb   = mem_en ? mem_arr[mem_addr[7:0]] : 32'hBAD0BAD0;
    mem_rdata = (lat_now <= 1) ? rd_comb : pipe[lat_now-2];
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(8'(i));
    end else if (mem_en && mem_we) begin
      mem_arr[mem_addr[7:0]] <= mem_wdata;
    end
    pipe[0] <= rd_comb;
    for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s dut=%0d cyc=%0d got=%h exp=%h", tag, sel, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] ctrl_of(input int k);
    return {cpu_gnt_a[k], dbg_gnt_a[k], cpu_rvalid_a[k], dbg_rvalid_a[k],
            mem_en_a[k], mem_we_a[k], busy_a[k], owner_a[k]};
  endfunction

  // Response monitor: every rvalid pops the oldest expected read.
  always @(negedge clk) begin
    if (rst_n && (cpu_rvalid || dbg_rvalid)) begin
      check("rvalid_both", 64'(cpu_rvalid && dbg_rvalid), 64'd0);
      if (sb_q.size() == 0) begin
        check("rvalid_unexp", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("rv_port", 64'(dbg_rvalid), 64'(mon_e.port));
        check("rv_data", 64'(dbg_rvalid ? dbg_rdata : cpu_rdata), 64'(mon_e.data));
        check("rv_cycle", 64'(cyc), 64'(mon_e.cyc));
        $display("read port=%0d data=%h cyc=%0d", dbg_rvalid, dbg_rvalid ? dbg_rdata : cpu_rdata, cyc);
      end
    end
  end

  task automatic push_exp(input bit port, input logic [31:0] addr, input int gcyc);
    exp_t e;
    e.port = port;
    e.data = ref_rd(addr[7:0]);
    e.cyc  = gcyc + cur_lat();
    sb_q.push_back(e);
  endtask

  // Drives a request at the current negedge, returns at the negedge of the grant cycle with req dropped.
  task automatic do_req(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int g);
    bit got = 1'b0;
    g = -1;
    if (port) begin
      dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (port ? dbg_gnt : cpu_gnt) begin
        got = 1'b1;
        g   = cyc;
      end
    end
    if (port) dbg_req = 1'b0;
    else      cpu_req = 1'b0;
    if (!got) begin
      check("gnt_timeout", 64'd0, 64'd1);
    end else begin
      check("gnt_other", 64'(port ? cpu_gnt : dbg_gnt), 64'd0);
      check("mem_en", 64'(mem_en), 64'd1);
      check("mem_we", 64'(mem_we), 64'(we));
      check("mem_addr", 64'(mem_addr), 64'(addr));
      check("owner", 64'(owner), 64'(port));
      check("busy_access", 64'(busy), 64'd1);
      $display("grant port=%0d we=%0d addr=%h cyc=%0d", port, we, addr, g);
      if (we) begin
        check("mem_wdata", 64'(mem_wdata), 64'(wdata));
        ref_wr[int'(addr[7:0])] = wdata;
      end else begin
        push_exp(port, addr, g);
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (sb_q.size() == 0 && !busy) break;
      @(negedge clk);
    end
    check("drain", 64'({sb_q.size() != 0, busy}), 64'd0);
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_ctrl", 64'(ctrl_of(k)), 64'd0);
      check("rst_data", {cpu_rdata_a[k] | dbg_rdata_a[k], mem_addr_a[k] | mem_wdata_a[k]}, 64'd0);
    end
    sb_q.delete();
    ref_wr.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released cyc=%0d", cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   g, g2, ngr;
    bit   seen;
    logic [3:0] exp_seq, seq;

    #1;
    sel = 0;
    assert_reset();

    // MEM_LAT=1 CPU read of 0x10
    do_req(1'b0, 1'b0, 32'h10, 32'h0, g);
    @(negedge clk);
    @(negedge clk);
    check("busy_after_read", 64'(busy), 64'd0);
    check("rdata_hold", 64'(cpu_rdata), 64'hDEADBEEF);

    // Debug request raised during the CPU access cycle
    do_req(1'b0, 1'b0, 32'h10, 32'h0, g);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h14;
    @(negedge clk);
    check("late_gnt_resp", 64'(dbg_gnt), 64'd0);
    @(negedge clk);
    check("late_gnt_idle", 64'(dbg_gnt), 64'd0);
    @(negedge clk);
    check("late_gnt", 64'(dbg_gnt), 64'd1);
    check("late_mem_addr", 64'(mem_addr), 64'h14);
    dbg_req = 1'b0;
    if (dbg_gnt) push_exp(1'b1, 32'h14, cyc);
    wait_drain();

    // Both ports hold read requests for four grants
    assert_reset();
`ifdef MEM_ARB_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b0000;
`endif
    seq = 4'b0000;
    ngr = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h14;
    for (int i = 0; i < 40 && ngr < 4; i++) begin
      @(negedge clk);
      if (cpu_gnt || dbg_gnt) begin
        check("tie_dbg_gnt", 64'(dbg_gnt), 64'(exp_seq[ngr]));
        check("tie_cpu_gnt", 64'(cpu_gnt), 64'(!exp_seq[ngr]));
        check("tie_owner", 64'(owner), 64'(exp_seq[ngr]));
        $display("tie grant %0d owner=%0d cyc=%0d", ngr, owner, cyc);
        seq[ngr] = dbg_gnt;
        push_exp(exp_seq[ngr], exp_seq[ngr] ? 32'h14 : 32'h10, cyc);
        ngr++;
      end
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    check("tie_count", 64'(ngr), 64'd4);
    check("tie_seq", 64'(seq), 64'(exp_seq));
    wait_drain();

    // MEM_LAT=3: debug write then CPU read of the same word
    sel = 1;
    @(negedge clk);
    do_req(1'b1, 1'b1, 32'h20, 32'h12345678, g);
    @(negedge clk);
    check("wr_busy", 64'(busy), 64'd0);
    check("wr_mem_we_off", 64'(mem_we), 64'd0);
    check("wr_wdata_hold", 64'(mem_wdata), 64'h12345678);
    do_req(1'b0, 1'b0, 32'h20, 32'h0, g2);
    check("rd_after_wr_gnt", 64'(g2), 64'(g + 2));
    wait_drain();
    check("addr_hold", 64'(mem_addr), 64'h20);

    // MEM_LAT=4: normal read, then reset while waiting on a second read
    sel = 2;
    @(negedge clk);
    do_req(1'b0, 1'b0, 32'h10, 32'h0, g);
    wait_drain();
    check("l4_rdata", 64'(cpu_rdata), 64'hDEADBEEF);
    do_req(1'b0, 1'b0, 32'h14, 32'h0, g);
    @(negedge clk);
    check("wait_busy", 64'(busy), 64'd1);
    check("wait_mem_en", 64'(mem_en), 64'd0);
    assert_reset();
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cpu_rvalid || dbg_rvalid) seen = 1'b1;
    end
    check("no_rvalid_after_rst", 64'(seen), 64'd0);
    do_req(1'b0, 1'b0, 32'h14, 32'h0, g);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
